udma_i2s_clkws_gen: RTL and testbench
=====================================

Name: udma_i2s_clkws_gen

Overview:
- Generates the I2S serial clock (SCK) and word select (WS) for one I2S clock domain.
- Driven by the gen-clock configuration of the I2S register interface: clock enable, 16-bit divider and bits-per-word.
- Returns the live running status that the register interface reads back as the clock-enable bit.
- Instantiated twice per I2S peripheral (cfg0, cfg1). Its SCK/WS and edge strobes feed the I2S/PDM receive shifters.

Parameters:
- DIV_WIDTH, 16, width of the clock divider field.
- BITS_WIDTH, 5, width of the bits-per-word field; word length is value+1.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous reset, active low
- cfg_clk_en_i  in  1  requested generator enable (level)
- cfg_clk_div_i  in  DIV_WIDTH  SCK half-period minus 1, in clk_i cycles
- cfg_bits_word_i  in  BITS_WIDTH  bits per channel word minus 1
- clk_en_o  out  1  generator running status (readback)
- sck_o  out  1  generated serial clock, registered
- ws_o  out  1  word select, registered; 0 = left, 1 = right
- sck_rise_o  out  1  one-cycle strobe, coincident with sck_o going 0->1
- sck_fall_o  out  1  one-cycle strobe, coincident with sck_o going 1->0
- frame_start_o  out  1  one-cycle strobe at start of each left word

Behaviour:
- One clock domain, clk_i. Reset is asynchronous, active-low on rstn_i.
- Reset values: all outputs 0; state IDLE; counters 0; latched div/bits 0.
- Reset mid-operation: outputs drop to 0 immediately (asynchronously). No partial frame resumes.
- State machine: IDLE, RUN, STOP.
- IDLE -> RUN when cfg_clk_en_i=1. On this transition:
  - latch div_q <= cfg_clk_div_i and bits_q <= cfg_bits_word_i;
  - div_cnt=0, bit_cnt=0, sck_o=0, ws_o=0;
  - clk_en_o=1 and frame_start_o=1 in the next cycle.
- RUN -> STOP when cfg_clk_en_i=0.
- STOP -> RUN when cfg_clk_en_i=1 again before the frame ends. No glitch; frame continues.
- STOP -> IDLE at the frame boundary.
- Divider (RUN and STOP):
  - div_cnt increments each cycle.
  - When div_cnt==div_q: div_cnt <= 0 and sck_o toggles.
  - SCK period = 2*(div_q+1) clk_i cycles. div_q=0 gives clk_i/2.
  - The matching strobe (sck_rise_o or sck_fall_o) asserts in the same cycle sck_o changes.
- Bit counter advances on each SCK falling edge:
  - If bit_cnt==bits_q: bit_cnt <= 0 and ws_o toggles.
  - Otherwise bit_cnt increments.
- Frame boundary: a falling-edge event where ws_o toggles 1->0.
  - Reload div_q and bits_q from the inputs. Mid-frame config changes take effect only here.
  - In RUN: frame_start_o=1 for that cycle.
  - In STOP: go to IDLE. sck_o=0, ws_o=0 (already 0 at that edge). clk_en_o=0 the same cycle. No frame_start_o.
- Frame length = 2*(bits_q+1) SCK periods. The stop delay never exceeds one frame.
- clk_en_o is 1 in RUN and STOP, 0 in IDLE. It lags cfg_clk_en_i by 1 cycle on start and by up to one frame on stop.
- Strobes are mutually exclusive with each other except that frame_start_o coincides with sck_fall_o.
- sck_rise_o, sck_fall_o and frame_start_o are never asserted in IDLE.
- Simultaneous events:
  - Disable in the same cycle as a frame-boundary falling edge in RUN: the boundary is processed as RUN (new frame starts, frame_start_o=1). STOP applies from the next cycle and completes at the following boundary.
- Width rules:
  - div_cnt is DIV_WIDTH bits, so max half-period is 2^DIV_WIDTH cycles.
  - bit_cnt is BITS_WIDTH bits; bits_q=31 gives 32-bit words. No overflow is possible.

Test Plan:
- Reset, then en=1, div=0, bits=7 -> clk_en_o=1 after 1 cycle. sck period 2 cycles. ws toggles every 16 cycles. frame_start_o every 32 cycles, first in the cycle after enable.
- div=3, bits=15 -> sck high 4 / low 4 cycles. ws low 128 cycles then high 128. Rise/fall strobes align exactly with sck_o edges.
- Running div=1, bits=3; deassert en during the left word -> SCK continues through the right word. At the ws 1->0 edge: clk_en_o=0, sck_o=0, ws_o=0. No further strobes.
- Running div=1, bits=3; change to div=0, bits=1 mid-frame -> old timing holds until the frame boundary. New sck period of 2 cycles and 4-cycle words start exactly at frame_start_o.
- Deassert then reassert en within one frame (STOP->RUN) -> no gap in SCK and clk_en_o stays 1. Separately, assert rstn_i=0 mid-word -> all outputs 0 asynchronously; after release with en=1, a fresh frame starts with ws_o=0.

Source files
------------

// File: rtl/udma_i2s_clkws_gen.sv
// I2S serial clock / word-select generator for one clock domain.
// Produces SCK, WS, edge strobes and frame start from the gen-clock configuration.
module udma_i2s_clkws_gen #(
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned BITS_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cfg_clk_en_i,
    input  logic [DIV_WIDTH-1:0]  cfg_clk_div_i,
    input  logic [BITS_WIDTH-1:0] cfg_bits_word_i,
    output logic                  clk_en_o,
    output logic                  sck_o,
    output logic                  ws_o,
    output logic                  sck_rise_o,
    output logic                  sck_fall_o,
    output logic                  frame_start_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    state_e                state_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [BITS_WIDTH-1:0] bits_q;
    logic [DIV_WIDTH-1:0]  div_cnt_q;
    logic [BITS_WIDTH-1:0] bit_cnt_q;
    logic                  sck_q;
    logic                  ws_q;
    logic                  clk_en_q;
    logic                  rise_q;
    logic                  fall_q;
    logic                  frame_start_q;

    logic tick;
    logic fall_ev;
    logic word_end;
    logic boundary;
    logic stop_now;

    assign tick     = (div_cnt_q == div_q);
    assign fall_ev  = tick && sck_q;
    assign word_end = (bit_cnt_q == bits_q);
    assign boundary = fall_ev && word_end && ws_q;
    // A STOP re-enabled on the boundary cycle keeps running as if never stopped.
    assign stop_now = (state_q == STOP) && !cfg_clk_en_i && boundary;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= IDLE;
            div_q         <= '0;
            bits_q        <= '0;
            div_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            sck_q         <= 1'b0;
            ws_q          <= 1'b0;
            clk_en_q      <= 1'b0;
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            frame_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_clk_en_i) begin
                        state_q       <= RUN;
                        div_q         <= cfg_clk_div_i;
                        bits_q        <= cfg_bits_word_i;
                        div_cnt_q     <= '0;
                        bit_cnt_q     <= '0;
                        sck_q         <= 1'b0;
                        ws_q          <= 1'b0;
                        clk_en_q      <= 1'b1;
                        frame_start_q <= 1'b1;
                    end
                end
                RUN, STOP: begin
                    if (stop_now) begin
                        state_q   <= IDLE;
                        div_q     <= cfg_clk_div_i;
                        bits_q    <= cfg_bits_word_i;
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        sck_q     <= 1'b0;
                        ws_q      <= 1'b0;
                        clk_en_q  <= 1'b0;
                    end else begin
                        state_q <= cfg_clk_en_i ? RUN : STOP;
                        if (tick) begin
                            div_cnt_q <= '0;
                            sck_q     <= ~sck_q;
                            rise_q    <= ~sck_q;
                            fall_q    <= sck_q;
                        end else begin
                            div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
                        end
                        if (fall_ev) begin
                            if (word_end) begin
                                bit_cnt_q <= '0;
                                ws_q      <= ~ws_q;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BITS_WIDTH'(1);
                            end
                        end
                        if (boundary) begin
                            div_q         <= cfg_clk_div_i;
                            bits_q        <= cfg_bits_word_i;
                            frame_start_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clk_en_o      = clk_en_q;
    assign sck_o         = sck_q;
    assign ws_o          = ws_q;
    assign sck_rise_o    = rise_q;
    assign sck_fall_o    = fall_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_udma_i2s_clkws_gen.sv
// Directed bench for udma_i2s_clkws_gen: sample index s counts negedges after each enable.
module tb_udma_i2s_clkws_gen;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [15:0] div;
    logic [4:0]  bits;
    logic        clk_en, sck, ws, rise, fall, fs;

    int n_asserts = 0;
    int n_fails   = 0;
    int s         = 0;
    int strobes   = 0;
    logic prev_sck = 1'b0;

    udma_i2s_clkws_gen #(.DIV_WIDTH(16), .BITS_WIDTH(5)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .cfg_clk_en_i   (en),
        .cfg_clk_div_i  (div),
        .cfg_bits_word_i(bits),
        .clk_en_o       (clk_en),
        .sck_o          (sck),
        .ws_o           (ws),
        .sck_rise_o     (rise),
        .sck_fall_o     (fall),
        .frame_start_o  (fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to sample t; every sample checks strobe alignment with observed SCK edges.
    task automatic adv_to(input int t);
        while (s < t) begin
            @(negedge clk);
            s++;
            chk("rise_align", rise, !prev_sck && sck);
            chk("fall_align", fall, prev_sck && !sck && clk_en);
            prev_sck = sck;
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; div = '0; bits = '0;
        adv_to(2);
        chk("rst_clk_en", clk_en, 0); chk("rst_sck", sck, 0); chk("rst_ws", ws, 0);
        chk("rst_fs", fs, 0);
        rstn = 1'b1;
        adv_to(4);
        chk("idle_clk_en", clk_en, 0);

        // Test 1: div=0, bits=7
        en = 1'b1; div = 16'd0; bits = 5'd7; s = 0;
        adv_to(1);
        chk("t1_clk_en", clk_en, 1); chk("t1_fs_first", fs, 1); chk("t1_sck0", sck, 0);
        adv_to(2);  chk("t1_rise", rise, 1); chk("t1_fs_off", fs, 0);
        adv_to(3);  chk("t1_fall", fall, 1);
        adv_to(16); chk("t1_ws16", ws, 0);
        adv_to(17); chk("t1_ws17", ws, 1);
        adv_to(32); chk("t1_fs32", fs, 0);
        adv_to(33); chk("t1_fs33", fs, 1); chk("t1_ws33", ws, 0);

        // Test 2: div=3, bits=15 written mid-frame, effective at s65
        adv_to(40); div = 16'd3; bits = 5'd15;
        adv_to(65); chk("t2_fs65", fs, 1);
        adv_to(66); chk("t2_old_hold_sck", sck, 0);
        adv_to(68); chk("t2_sck68", sck, 0);
        adv_to(69); chk("t2_rise69", rise, 1); chk("t2_sck69", sck, 1);
        adv_to(72); chk("t2_sck72", sck, 1);
        adv_to(73); chk("t2_fall73", fall, 1);
        adv_to(192); chk("t2_ws192", ws, 0);
        adv_to(193); chk("t2_ws193", ws, 1);
        adv_to(320); chk("t2_fs320", fs, 0); chk("t2_ws320", ws, 1);
        adv_to(321); chk("t2_fs321", fs, 1); chk("t2_ws321", ws, 0);

        // Test 3: div=1, bits=3, disable during left word
        rstn = 1'b0; en = 1'b0; s = 0;
        adv_to(1);
        rstn = 1'b1; en = 1'b1; div = 16'd1; bits = 5'd3; s = 0;
        adv_to(1);  chk("t3_fs1", fs, 1);
        adv_to(2);  chk("t3_sck2", sck, 0);
        adv_to(3);  chk("t3_rise3", rise, 1);
        adv_to(17); chk("t3_ws17", ws, 1);
        adv_to(33); chk("t3_fs33", fs, 1);
        adv_to(34); en = 1'b0;
        adv_to(49); chk("t3_ws49", ws, 1); chk("t3_clk_en49", clk_en, 1);
        adv_to(64); chk("t3_clk_en64", clk_en, 1); chk("t3_sck64", sck, 1);
        adv_to(65);
        chk("t3_stop_clk_en", clk_en, 0); chk("t3_stop_sck", sck, 0);
        chk("t3_stop_ws", ws, 0); chk("t3_stop_fs", fs, 0);
        for (int i = 66; i <= 80; i++) begin
            adv_to(i);
            strobes += int'(rise) + int'(fall) + int'(fs);
        end
        chk("t3_no_strobes", strobes, 0);
        chk("t3_idle_sck", sck, 0);

        // Test 4: div=1, bits=3 then div=0, bits=1 mid-frame
        en = 1'b1; div = 16'd1; bits = 5'd3; s = 0;
        adv_to(10); div = 16'd0; bits = 5'd1;
        adv_to(16); chk("t4_ws16", ws, 0);
        adv_to(17); chk("t4_ws17", ws, 1);
        adv_to(32); chk("t4_sck32", sck, 1);
        adv_to(33); chk("t4_fs33", fs, 1); chk("t4_fall33", fall, 1);
        adv_to(34); chk("t4_rise34", rise, 1); chk("t4_fs34", fs, 0);
        adv_to(35); chk("t4_ws35", ws, 0);
        adv_to(37); chk("t4_ws37", ws, 1);
        adv_to(41); chk("t4_fs41", fs, 1); chk("t4_ws41", ws, 0);

        // Test 5: STOP -> RUN within a frame keeps SCK running
        adv_to(42); en = 1'b0;
        for (int k = 43; k <= 56; k++) begin
            adv_to(k);
            if (k == 44) en = 1'b1;
            chk("t5_sck", sck, ((k - 41) % 2 == 1));
            chk("t5_clk_en", clk_en, 1);
            chk("t5_fs", fs, (k == 49));
        end
        // Disable landing on a RUN boundary: frame still starts, stop at next boundary
        en = 1'b0;
        adv_to(57); chk("t5_fs57", fs, 1); chk("t5_clk_en57", clk_en, 1);
        adv_to(64); chk("t5_clk_en64", clk_en, 1); chk("t5_ws64", ws, 1);
        adv_to(65); chk("t5_clk_en65", clk_en, 0); chk("t5_sck65", sck, 0);
        chk("t5_fs65", fs, 0);

        // Test 6: asynchronous reset mid-word
        adv_to(66);
        en = 1'b1; div = 16'd0; bits = 5'd7; s = 0;
        adv_to(18); chk("t6_pre_sck", sck, 1); chk("t6_pre_ws", ws, 1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_async_clk_en", clk_en, 0); chk("t6_async_sck", sck, 0);
        chk("t6_async_ws", ws, 0); chk("t6_async_rise", rise, 0);
        chk("t6_async_fall", fall, 0); chk("t6_async_fs", fs, 0);
        adv_to(19);
        rstn = 1'b1; s = 0;
        adv_to(1); chk("t6_fs1", fs, 1); chk("t6_clk_en1", clk_en, 1); chk("t6_ws1", ws, 0);
        adv_to(2); chk("t6_rise2", rise, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
